// File: rtl/zap_cp15_pkg.sv
// Shared definitions for the CP15 coprocessor unit.
// Holds the FSM state encoding, CRn register numbers, the c0 ID value and
// a decode helper that tells register transfers (MRC/MCR to p15) apart
// from everything else the predecoder may hand over.
package zap_cp15_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_READ, S_EXEC, S_MAINT, S_DONE, S_ACK
  } cp15_state_t;

  localparam logic [3:0]  CRN_ID    = 4'd0;
  localparam logic [3:0]  CRN_CTRL  = 4'd1;
  localparam logic [3:0]  CRN_BADDR = 4'd2;
  localparam logic [3:0]  CRN_DAC   = 4'd3;
  localparam logic [3:0]  CRN_FSR   = 4'd5;
  localparam logic [3:0]  CRN_FAR   = 4'd6;
  localparam logic [3:0]  CRN_CACHE = 4'd7;
  localparam logic [3:0]  CRN_TLB   = 4'd8;

  localparam logic [3:0]  CP15_NUM  = 4'd15;
  localparam logic [31:0] CP15_ID   = 32'h4107_0000;

  // MRC/MCR to p15: coproc number 15, register-transfer class (1110) with bit4 set.
  // LDC/STC/CDP and other coprocessors are acknowledged without effect.
  function automatic logic is_cp15_xfer(input logic [31:0] w);
    return (w[11:8] == CP15_NUM) && (w[27:24] == 4'b1110) && w[4];
  endfunction

endpackage

// File: rtl/zap_cp15_regbank.sv
// CP15 architectural register bank: c1 control, c2 table base, c3 domain
// access, c5 fault status, c6 fault address, plus the read mux (c0 ID).
// Ports: i_clk/i_reset (sync, active-high); i_wr_en/i_wr_crn/i_wr_data
// software write; i_rd_crn/o_rd_data read mux; i_fault_dav/i_fsr/i_far MMU
// fault load (wins over a software write to c5/c6); o_* control outputs.
module zap_cp15_regbank
  import zap_cp15_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_wr_en,
  input  logic [3:0]  i_wr_crn,
  input  logic [31:0] i_wr_data,
  input  logic [3:0]  i_rd_crn,
  output logic [31:0] o_rd_data,
  input  logic        i_fault_dav,
  input  logic [7:0]  i_fsr,
  input  logic [31:0] i_far,
  output logic        o_mmu_en,
  output logic        o_dcache_en,
  output logic        o_icache_en,
  output logic [31:0] o_baddr,
  output logic [31:0] o_dac
);

  logic [7:0]  fsr;
  logic [31:0] far;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_mmu_en    <= 1'b0;
      o_dcache_en <= 1'b0;
      o_icache_en <= 1'b0;
      o_baddr     <= '0;
      o_dac       <= '0;
    end else if (i_wr_en) begin
      case (i_wr_crn)
        CRN_CTRL: begin
          o_mmu_en    <= i_wr_data[0];
          o_dcache_en <= i_wr_data[2];
          o_icache_en <= i_wr_data[12];
        end
        // Table base is 16KB aligned.
        CRN_BADDR: o_baddr <= {i_wr_data[31:14], 14'd0};
        CRN_DAC:   o_dac   <= i_wr_data;
        default: ;
      endcase
    end
  end

  // Hardware fault report has priority over a software write in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      fsr <= '0;
      far <= '0;
    end else if (i_fault_dav) begin
      fsr <= i_fsr;
      far <= i_far;
    end else if (i_wr_en && i_wr_crn == CRN_FSR) begin
      fsr <= i_wr_data[7:0];
    end else if (i_wr_en && i_wr_crn == CRN_FAR) begin
      far <= i_wr_data;
    end
  end

  always_comb begin
    o_rd_data = '0;
    case (i_rd_crn)
      CRN_ID:    o_rd_data = CP15_ID;
      CRN_CTRL:  o_rd_data = {19'd0, o_icache_en, 9'd0, o_dcache_en, 1'b0, o_mmu_en};
      CRN_BADDR: o_rd_data = o_baddr;
      CRN_DAC:   o_rd_data = o_dac;
      CRN_FSR:   o_rd_data = {24'd0, fsr};
      CRN_FAR:   o_rd_data = far;
      default:   o_rd_data = '0;
    endcase
  end

endmodule

// File: rtl/zap_cp15_unit.sv
// CP15 system-control coprocessor. Accepts one coprocessor instruction per
// dav handshake, performs MRC (CP15 -> CPU reg) / MCR (CPU reg -> CP15),
// and for c7/c8 writes issues cache/TLB maintenance requests.
// Ports: i_clk/i_reset (sync, active-high); i_copro_dav/word/reg request,
// o_copro_done completion pulse; o_reg_rd_ndx/i_reg_rd_data register read
// (data one cycle after index); o_reg_wr_* register write; i_fault_dav/fsr/far
// MMU fault; o_*_en, o_baddr, o_dac control; o_*_inv / i_*_inv_done maintenance.
// Build option: define CP15_CACHE_MAINT_EN to enable c7/c8 maintenance
// requests; otherwise those writes complete immediately and o_*_inv stay 0.
module zap_cp15_unit
  import zap_cp15_pkg::*;
#(
  parameter  int PHY_REGS = 46,
  localparam int RW       = $clog2(PHY_REGS)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_copro_dav,
  input  logic [31:0]   i_copro_word,
  input  logic [RW-1:0] i_copro_reg,
  output logic          o_copro_done,
  output logic [RW-1:0] o_reg_rd_ndx,
  input  logic [31:0]   i_reg_rd_data,
  output logic          o_reg_wr_en,
  output logic [RW-1:0] o_reg_wr_ndx,
  output logic [31:0]   o_reg_wr_data,
  input  logic          i_fault_dav,
  input  logic [7:0]    i_fsr,
  input  logic [31:0]   i_far,
  output logic          o_mmu_en,
  output logic          o_dcache_en,
  output logic          o_icache_en,
  output logic [31:0]   o_baddr,
  output logic [31:0]   o_dac,
  output logic          o_dcache_inv,
  output logic          o_icache_inv,
  output logic          o_tlb_inv,
  input  logic          i_dcache_inv_done,
  input  logic          i_icache_inv_done,
  input  logic          i_tlb_inv_done
);

  cp15_state_t   state;
  logic [31:0]   word_q;
  logic [RW-1:0] reg_q;
  logic [31:0]   cp_rd_data;

  wire       is_mrc = word_q[20];
  wire [3:0] crn    = word_q[19:16];

  logic unused_bits;
  assign unused_bits = ^{word_q[31:28], word_q[23:21], word_q[15:12], word_q[3:0]};

  zap_cp15_regbank u_regbank (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_wr_en     (state == S_EXEC && !is_mrc),
    .i_wr_crn    (crn),
    .i_wr_data   (i_reg_rd_data),
    .i_rd_crn    (crn),
    .o_rd_data   (cp_rd_data),
    .i_fault_dav (i_fault_dav),
    .i_fsr       (i_fsr),
    .i_far       (i_far),
    .o_mmu_en    (o_mmu_en),
    .o_dcache_en (o_dcache_en),
    .o_icache_en (o_icache_en),
    .o_baddr     (o_baddr),
    .o_dac       (o_dac)
  );

`ifdef CP15_CACHE_MAINT_EN
  logic ic_req, dc_req, tlb_req;
  wire [2:0] op2     = word_q[7:5];
  wire       set_ic  = !is_mrc && crn == CRN_CACHE && (op2 == 3'd0 || op2 == 3'd5);
  wire       set_dc  = !is_mrc && crn == CRN_CACHE && (op2 == 3'd0 || op2 == 3'd6);
  wire       set_tlb = !is_mrc && crn == CRN_TLB;
  // A request drops on the edge its ack is sampled; MAINT exits once all are down.
  wire       ic_nxt  = ic_req  & ~i_icache_inv_done;
  wire       dc_nxt  = dc_req  & ~i_dcache_inv_done;
  wire       tlb_nxt = tlb_req & ~i_tlb_inv_done;
`else
  wire ic_req = 1'b0, dc_req = 1'b0, tlb_req = 1'b0;
  logic unused_maint;
  assign unused_maint = ^{i_dcache_inv_done, i_icache_inv_done, i_tlb_inv_done, word_q[7:5]};
`endif

  assign o_icache_inv = ic_req;
  assign o_dcache_inv = dc_req;
  assign o_tlb_inv    = tlb_req;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= S_IDLE;
      word_q        <= '0;
      reg_q         <= '0;
      o_copro_done  <= 1'b0;
      o_reg_rd_ndx  <= '0;
      o_reg_wr_en   <= 1'b0;
      o_reg_wr_ndx  <= '0;
      o_reg_wr_data <= '0;
`ifdef CP15_CACHE_MAINT_EN
      ic_req        <= 1'b0;
      dc_req        <= 1'b0;
      tlb_req       <= 1'b0;
`endif
    end else begin
      o_copro_done <= 1'b0;
      o_reg_wr_en  <= 1'b0;
      o_reg_rd_ndx <= '0;
      case (state)
        S_IDLE: if (i_copro_dav) begin
          word_q <= i_copro_word;
          reg_q  <= i_copro_reg;
          state  <= S_FETCH;
        end
        S_FETCH: begin
          if (!is_cp15_xfer(word_q)) begin
            state        <= S_DONE;
            o_copro_done <= 1'b1;
          end else if (is_mrc) begin
            // Write strobe is live for the single EXEC cycle.
            state         <= S_EXEC;
            o_reg_wr_en   <= 1'b1;
            o_reg_wr_ndx  <= reg_q;
            o_reg_wr_data <= cp_rd_data;
          end else begin
            state        <= S_READ;
            o_reg_rd_ndx <= reg_q;
          end
        end
        // Register file returns data during EXEC; regbank write happens there.
        S_READ: state <= S_EXEC;
        S_EXEC: begin
`ifdef CP15_CACHE_MAINT_EN
          if (set_ic || set_dc || set_tlb) begin
            state   <= S_MAINT;
            ic_req  <= set_ic;
            dc_req  <= set_dc;
            tlb_req <= set_tlb;
          end else begin
            state        <= S_DONE;
            o_copro_done <= 1'b1;
          end
`else
          state        <= S_DONE;
          o_copro_done <= 1'b1;
`endif
        end
        S_MAINT: begin
`ifdef CP15_CACHE_MAINT_EN
          ic_req  <= ic_nxt;
          dc_req  <= dc_nxt;
          tlb_req <= tlb_nxt;
          if (!(ic_nxt || dc_nxt || tlb_nxt)) begin
            state        <= S_DONE;
            o_copro_done <= 1'b1;
          end
`else
          state <= S_IDLE;
`endif
        end
        S_DONE: state <= S_ACK;
        // Wait for the predecoder to drop dav so a held request is not replayed.
        S_ACK:  if (!i_copro_dav) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/zap_cp15_unit.md
ZAP_CP15_UNIT -- requirements
Module: zap_cp15_unit

Interface
REQ-001 SHALL have parameter PHY_REGS, default 46, meaning the number of physical CPU registers; index width RW = $clog2(PHY_REGS).
REQ-002 SHALL have ports (name, direction, width, meaning):
- i_clk  in  1  clock.
- i_reset  in  1  reset, synchronous, active-high.
- i_copro_dav  in  1  coprocessor request valid, from predecode.
- i_copro_word  in  32  full coprocessor instruction.
- i_copro_reg  in  RW  translated CPU register index.
- o_copro_done  out  1  one-cycle completion pulse to predecode.
- o_reg_rd_ndx  out  RW  CPU register file read index.
- i_reg_rd_data  in  32  read data, valid one cycle after the index.
- o_reg_wr_en  out  1  CPU register write strobe.
- o_reg_wr_ndx  out  RW  CPU register write index.
- o_reg_wr_data  out  32  CPU register write data.
- i_fault_dav  in  1  MMU fault report strobe.
- i_fsr  in  8  fault status.
- i_far  in  32  fault address.
- o_mmu_en, o_dcache_en, o_icache_en  out  1 each  control bits.
- o_baddr  out  32  translation table base.
- o_dac  out  32  domain access control.
- o_dcache_inv, o_icache_inv, o_tlb_inv  out  1 each  maintenance requests.
- i_dcache_inv_done, i_icache_inv_done, i_tlb_inv_done  in  1 each  maintenance acknowledges.

Function
REQ-003 SHALL implement FSM states IDLE, FETCH, READ, EXEC, MAINT, DONE, ACK.
REQ-004 IDLE SHALL go to FETCH when i_copro_dav=1, latching i_copro_word and i_copro_reg.
REQ-005 FETCH SHALL go to DONE when the request is a non-CP15 request (word[11:8]!=15) or an LDC/STC/CDP (word[27:24]!=4'b1110 or word[4]=0); no side effects.
REQ-006 MRC (word[20]=1) SHALL go FETCH->EXEC: o_reg_wr_en=1 for exactly one cycle with o_reg_wr_ndx=latched index and o_reg_wr_data=the selected CP15 register, then DONE.
REQ-007 MCR (word[20]=0) SHALL go FETCH->READ driving o_reg_rd_ndx=latched index, then EXEC, where i_reg_rd_data is written into the selected CP15 register, then DONE.
REQ-008 CRn=word[19:16] SHALL map as follows:
- c1 = control; bit0 drives o_mmu_en, bit2 o_dcache_en, bit12 o_icache_en; other bits read 0.
- c2 = o_baddr; bits[13:0] are forced to 0.
- c3 = o_dac.
- c5 = {24'd0, FSR}.
- c6 = FAR.
- c0 reads 32'h4107_0000.
- Any other CRn reads 0 and ignores writes.
REQ-009 MCR to c7 SHALL go EXEC->MAINT:
- opcode2 (word[7:5]) = 0 raises o_icache_inv and o_dcache_inv.
- opcode2 = 5 raises o_icache_inv only.
- opcode2 = 6 raises o_dcache_inv only.
- Each raised request SHALL be held high until its done input is seen (sampled or sticky).
- MAINT SHALL go to DONE only when every raised request is acknowledged.
REQ-010 MCR to c8 SHALL raise o_tlb_inv with the same MAINT rules.
REQ-011 DONE SHALL assert o_copro_done for exactly one cycle, then go to ACK; ACK SHALL return to IDLE only when i_copro_dav=0, so a held dav never starts a second operation.
REQ-012 Latency from dav to done SHALL be: 2 cycles for no-op, 3 for MRC, 4 for MCR without maintenance.
REQ-013 i_fault_dav=1 SHALL load FSR and FAR in any state; when it coincides with an MCR write to c5 or c6, the fault SHALL win.
REQ-014 Outside EXEC, o_reg_wr_en SHALL be 0; o_reg_rd_ndx SHALL be 0 outside READ.

Reset
REQ-015 i_reset SHALL, mid-operation included, force:
- the FSM to IDLE;
- all control bits, o_baddr, o_dac, FSR and FAR to 0;
- o_copro_done, o_reg_wr_en and all maintenance requests to 0.

Configuration
REQ-016 Macro CP15_CACHE_MAINT_EN SHALL control c7/c8 maintenance:
- When defined, REQ-009 and REQ-010 apply.
- When undefined, c7/c8 writes SHALL go EXEC->DONE directly, the maintenance outputs SHALL be constant 0, and the done inputs SHALL be ignored.

Structure
REQ-017 State encodings, CRn constants and the c0 ID value SHALL live in shared package zap_cp15_pkg.
REQ-018 The CP15 register bank (c1/c2/c3/c5/c6, with fault-priority write logic) SHALL be sub-module zap_cp15_regbank; the FSM stays in the top.

Verification
REQ-019 MCR p15,c1 with source reg data 32'h0000_1005 -> o_mmu_en=o_dcache_en=o_icache_en=1; done at cycle 4.
REQ-020 MRC p15,c0 into reg 3 -> a single wr_en pulse with ndx=3, data=32'h4107_0000; done at cycle 3.
REQ-021 MCR c7 opcode2=0 with i_dcache_inv_done 2 cycles before i_icache_inv_done -> done only after both acks; each request drops after its own ack.
REQ-022 Request with word[11:8]=14 -> done at cycle 2, no register write, CP15 state unchanged; dav held for 5 cycles -> no second done.
REQ-023 i_fault_dav with i_far=32'hDEAD_BEEF in the same cycle as an MCR c6 with data 0 -> FAR=32'hDEAD_BEEF.
REQ-024 i_reset during MAINT -> next cycle FSM IDLE, all requests 0, o_dac=0.
